// File: rtl/uart_pkg.sv
// Shared UART receive constants: FSM encodings, shift-register width, frame modes.
// Mode index is {EIGHT, PEN} as latched at frame start.
package uart_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam int SR_W = 10;

  localparam logic [1:0] MODE_7N = 2'b00;
  localparam logic [1:0] MODE_7P = 2'b01;
  localparam logic [1:0] MODE_8N = 2'b10;
  localparam logic [1:0] MODE_8P = 2'b11;

  typedef struct packed {
    logic eight;
    logic pen;
    logic ohel;
  } rx_cfg_t;

  localparam rx_cfg_t CFG_RST = '0;

  function automatic logic [1:0] cfg_mode(input rx_cfg_t c);
    return {c.eight, c.pen};
  endfunction

endpackage

// File: rtl/rx_frame_check.sv
// Combinational field extraction plus parity and framing checks on a captured frame.
// Stop bit always lands in the MSB of the shift register; data/parity positions depend on mode.
module rx_frame_check
  import uart_pkg::*;
(
  input  logic [SR_W-1:0] sr_i,
  input  rx_cfg_t         cfg_i,
  output logic [7:0]      data_o,
  output logic            perr_o,
  output logic            ferr_o
);

  logic par;
  logic exp_par;

  always_comb begin
    data_o = 8'h00;
    par    = 1'b0;
    case (cfg_mode(cfg_i))
      MODE_7N: data_o = {1'b0, sr_i[8:2]};
      MODE_7P: begin
        data_o = {1'b0, sr_i[7:1]};
        par    = sr_i[8];
      end
      MODE_8N: data_o = sr_i[8:1];
      default: begin
        data_o = sr_i[7:0];
        par    = sr_i[8];
      end
    endcase
  end

  // Bit 7 is zero in 7-bit modes, so an 8-bit reduction is correct for both widths.
  assign exp_par = cfg_i.ohel ? ~^data_o : ^data_o;
  assign perr_o  = cfg_i.pen & (par != exp_par);
  assign ferr_o  = ~sr_i[SR_W-1];

endmodule

// File: rtl/rx_data_ctrl.sv
// UART receive datapath: shifts bits on BTU, reports the character one cycle after DONE.
// Overrun detection is built only when UART_RX_OVF_EN is defined; otherwise OVF is tied low.
module rx_data_ctrl
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       START,
  input  logic       BTU,
  input  logic       DONE,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       READ,
  output logic [7:0] RX_DATA,
  output logic       RXRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF
);

  logic [0:0]      state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  rx_cfg_t         cfg_q, cfg_d;
  rx_cfg_t         cfg_in;
  logic            start_q;
  logic            start_rise;
  logic            frame_done;

  logic [7:0]      data_q;
  logic            rdy_q;
  logic            perr_q;
  logic            ferr_q;

  logic [7:0]      chk_data;
  logic            chk_perr;
  logic            chk_ferr;

  assign cfg_in     = '{eight: EIGHT, pen: PEN, ohel: OHEL};
  assign start_rise = START & ~start_q;
  assign frame_done = (state_q == ST_RECV) && DONE && !start_rise;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cfg_d   = cfg_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RECV;
          sr_d    = '0;
          cfg_d   = cfg_in;
        end
      end
      default: begin
        // A fresh start edge mid-frame abandons the partial character.
        if (start_rise) begin
          sr_d  = '0;
          cfg_d = cfg_in;
        end else if (DONE) begin
          state_d = ST_IDLE;
        end else if (BTU && !START) begin
          sr_d = {RX, sr_q[SR_W-1:1]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cfg_q   <= CFG_RST;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cfg_q   <= cfg_d;
      start_q <= START;
    end
  end

  rx_frame_check u_check (
    .sr_i   (sr_q),
    .cfg_i  (cfg_q),
    .data_o (chk_data),
    .perr_o (chk_perr),
    .ferr_o (chk_ferr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'h00;
      rdy_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else if (frame_done) begin
      data_q <= chk_data;
      rdy_q  <= 1'b1;
      perr_q <= chk_perr;
      ferr_q <= chk_ferr;
    end else if (READ) begin
      rdy_q  <= 1'b0;
    end
  end

`ifdef UART_RX_OVF_EN
  logic ovf_q;

  // A read in the same cycle as DONE consumes the old character, so no overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (READ) begin
      ovf_q <= 1'b0;
    end else if (frame_done && rdy_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

  assign RX_DATA = data_q;
  assign RXRDY   = rdy_q;
  assign PERR    = perr_q;
  assign FERR    = ferr_q;

endmodule

// File: tb/tb_rx_data_ctrl.sv
// Directed scoreboard bench for rx_data_ctrl: stimulus queues expected output snapshots,
// a negedge monitor pops one whenever the output vector changes and checks value and cycle.
module tb_rx_data_ctrl;

`ifdef UART_RX_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       START = 1'b0;
  logic       BTU = 1'b0;
  logic       DONE = 1'b0;
  logic       EIGHT = 1'b0;
  logic       PEN = 1'b0;
  logic       OHEL = 1'b0;
  logic       READ = 1'b0;
  logic [7:0] RX_DATA;
  logic       RXRDY;
  logic       PERR;
  logic       FERR;
  logic       OVF;

  rx_data_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .START   (START),
    .BTU     (BTU),
    .DONE    (DONE),
    .EIGHT   (EIGHT),
    .PEN     (PEN),
    .OHEL    (OHEL),
    .READ    (READ),
    .RX_DATA (RX_DATA),
    .RXRDY   (RXRDY),
    .PERR    (PERR),
    .FERR    (FERR),
    .OVF     (OVF)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot layout: {RX_DATA, RXRDY, PERR, FERR, OVF}; cyc = -1 means any cycle.
  typedef struct {
    logic [11:0] v;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic        first = 1'b1;
  logic [11:0] prev = '0;
  logic [11:0] cur;
  exp_t        e;

  function automatic void push(input logic [11:0] v, input int c, input string nm);
    exp_t x;
    x.v   = v;
    x.cyc = c;
    x.nm  = nm;
    exp_q.push_back(x);
  endfunction

  always @(negedge clk) begin
    cur = {RX_DATA, RXRDY, PERR, FERR, OVF};
    if (mon_en && (first || cur !== prev)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change got=%h at cyc=%0d (no output change required)", cur, cyc);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
          bad++;
          $display("FAIL %s got=%h at cyc=%0d required=%h at cyc=%0d", e.nm, cur, cyc, e.v, e.cyc);
        end
      end
      first = 1'b0;
    end
    prev = cur;
  end

  task automatic send_frame(input logic [7:0] ch, input logic eight, input logic pen,
                            input logic ohel, input logic par, input logic stop,
                            input logic rd, input logic [7:0] x_data, input logic x_perr,
                            input logic x_ferr, input logic x_ovf, input string nm);
    logic [9:0] b;
    int n;
    b = '0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (eight || i < 7) begin
        b[n] = ch[i];
        n++;
      end
    end
    if (pen) begin
      b[n] = par;
      n++;
    end
    b[n] = stop;
    n++;
    @(posedge clk); #1;
    EIGHT = eight; PEN = pen; OHEL = ohel; START = 1'b1;
    RX = 1'b1; BTU = 1'b1;
    @(posedge clk); #1 BTU = 1'b0;
    @(posedge clk); #1 START = 1'b0;
    for (int i = 0; i < n; i++) begin
      RX = b[i]; BTU = 1'b1;
      @(posedge clk); #1 BTU = 1'b0;
      if (i == 0) begin
        EIGHT = ~eight; PEN = ~pen; OHEL = ~ohel;
      end
      @(posedge clk); #1;
    end
    RX = 1'b1;
    DONE = 1'b1; READ = rd;
    push({x_data, 1'b1, x_perr, x_ferr, x_ovf}, cyc + 1, nm);
    @(posedge clk); #1 DONE = 1'b0; READ = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] x, input string nm);
    @(posedge clk); #1 READ = 1'b1;
    push(x, cyc + 1, nm);
    @(posedge clk); #1 READ = 1'b0;
  endtask

  task automatic partial_frame();
    @(posedge clk); #1;
    EIGHT = 1'b0; PEN = 1'b0; OHEL = 1'b0; START = 1'b1;
    repeat (2) @(posedge clk);
    #1 START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RX = 1'b1; BTU = 1'b1;
      @(posedge clk); #1 BTU = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push(12'h000, -1, "reset_state");
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    send_frame(8'hA5, 1, 0, 0, 0, 1, 0, 8'hA5, 0, 0, 0, "8n1_a5");
    do_read(12'hA50, "read_a5");

    send_frame(8'h07, 1, 1, 0, 0, 1, 0, 8'h07, 1, 0, 0, "8e1_bad_par");
    do_read(12'h074, "read_8e1");
    send_frame(8'h07, 1, 1, 1, 0, 1, 0, 8'h07, 0, 0, 0, "8o1_good_par");
    do_read(12'h070, "read_8o1");

    send_frame(8'h41, 0, 0, 0, 0, 0, 0, 8'h41, 0, 1, 0, "7n1_ferr");
    do_read(12'h412, "read_7n1");

    send_frame(8'h11, 1, 0, 0, 0, 1, 0, 8'h11, 0, 0, 0, "ovf_first");
    send_frame(8'h22, 1, 0, 0, 0, 1, 0, 8'h22, 0, 0, OVF_EN, "ovf_second");
    do_read(12'h220, "read_ovf");

    send_frame(8'h33, 1, 0, 0, 0, 1, 0, 8'h33, 0, 0, 0, "pre_coinc");
    send_frame(8'h44, 1, 0, 0, 0, 1, 0, 8'h44, 0, 0, OVF_EN, "pre_coinc_ovf");
    send_frame(8'h55, 1, 0, 0, 0, 1, 1, 8'h55, 0, 0, 0, "read_with_done");

    partial_frame();
    send_frame(8'h66, 1, 0, 0, 0, 1, 0, 8'h66, 0, 0, OVF_EN, "restart_frame");

    partial_frame();
    rst = 1'b1;
    push(12'h000, cyc + 1, "rst_mid_frame");
    @(posedge clk); #1 rst = 1'b0; DONE = 1'b1;
    @(posedge clk); #1 DONE = 1'b0;
    repeat (3) @(posedge clk);
    send_frame(8'h3C, 1, 0, 0, 0, 1, 0, 8'h3C, 0, 0, 0, "after_rst_3c");

    send_frame(8'h03, 0, 1, 0, 1, 1, 0, 8'h03, 1, 0, OVF_EN, "7e1_bad_par");

    repeat (5) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s got=no_change required=%h at cyc=%0d", e.nm, e.v, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_data_ctrl.md
RX_DATA_CTRL -- requirements
Module: rx_data_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port RX, input, 1, serial line, already synchronized.
REQ-004 SHALL have port START, input, 1, high while RX_Controller is in the start-bit phase.
REQ-005 SHALL have port BTU, input, 1, one-cycle bit-time-up pulse from RX_Controller.
REQ-006 SHALL have port DONE, input, 1, one-cycle frame-complete pulse from RX_Controller.
REQ-007 SHALL have port EIGHT, input, 1, 1 = 8 data bits, 0 = 7 data bits.
REQ-008 SHALL have port PEN, input, 1, parity enable.
REQ-009 SHALL have port OHEL, input, 1, 0 = even parity, 1 = odd parity.
REQ-010 SHALL have port READ, input, 1, one-cycle host read strobe.
REQ-011 SHALL have port RX_DATA, output, 8, received character; bit 7 = 0 in 7-bit mode.
REQ-012 SHALL have port RXRDY, output, 1, character available.
REQ-013 SHALL have ports PERR, FERR, OVF, each output, 1, parity, framing and overrun status.

Function
REQ-014 SHALL use two states: IDLE → RECV when START=1; RECV → IDLE on DONE.
REQ-015 SHALL latch EIGHT, PEN and OHEL into a config register on the IDLE→RECV transition; input changes mid-frame SHALL have no effect until the next frame.
REQ-016 SHALL shift SR[9:0] <= {RX, SR[9:1]} on each BTU while in RECV with START=0; BTU in IDLE or with START=1 SHALL be ignored.
REQ-017 SHALL extract fields at DONE per latched {EIGHT,PEN}: 00 data=SR[8:2], stop=SR[9]; 01 data=SR[7:1], par=SR[8], stop=SR[9]; 10 data=SR[8:1], stop=SR[9]; 11 data=SR[7:0], par=SR[8], stop=SR[9].
REQ-018 SHALL load RX_DATA, PERR and FERR the cycle after DONE; RXRDY SHALL rise that same cycle (latency 1).
REQ-019 SHALL compute expected parity as ^data when OHEL=0 and ~^data when OHEL=1; PERR = PEN & (par != expected); PERR SHALL be 0 when PEN=0.
REQ-020 SHALL set FERR = ~stop.
REQ-021 SHALL clear RXRDY and OVF the cycle after READ; RX_DATA, PERR and FERR SHALL hold their values.
REQ-022 SHALL set OVF (sticky) when DONE arrives while RXRDY=1 and READ=0; new data SHALL overwrite RX_DATA.
REQ-023 SHALL, when READ and DONE coincide, load new data, keep RXRDY=1 and leave OVF unset.
REQ-024 SHALL discard a partial frame and not alter any output when START rises again while in RECV; SR SHALL clear and config SHALL re-latch.

Reset
REQ-025 SHALL, on rst, go to IDLE, clear SR and config, and drive RX_DATA=8'h00, RXRDY=0, PERR=0, FERR=0, OVF=0.
REQ-026 SHALL treat rst mid-frame the same as REQ-025; the subsequent DONE in IDLE SHALL be ignored.

Configuration
REQ-027 SHALL include overrun detection only when UART_RX_OVF_EN is defined; otherwise OVF SHALL be tied to 0 and overwrite SHALL occur silently.

Structure
REQ-028 SHALL take state encodings (IDLE, RECV), the SR width (10) and mode field constants from shared package uart_pkg.
REQ-029 SHALL place field extraction and parity/framing checks in sub-module rx_frame_check (combinational: SR and config in; data, PERR and FERR out).

Verification
REQ-030 SHALL cover 8N1, char 8'hA5, stop=1 → RX_DATA=A5, RXRDY=1 one cycle after DONE, PERR=0, FERR=0.
REQ-031 SHALL cover 8E1, char 8'h07, parity bit 0 (wrong) → PERR=1; with OHEL=1 the same bits → PERR=0.
REQ-032 SHALL cover 7N1, char 7'h41, stop bit 0 → RX_DATA=8'h41, FERR=1.
REQ-033 SHALL cover two frames 8'h11 then 8'h22 with no READ → RX_DATA=22, OVF=1; READ → RXRDY=0, OVF=0, RX_DATA=22.
REQ-034 SHALL cover READ coincident with DONE → RXRDY stays 1, OVF=0; and OVF stuck at 0 when UART_RX_OVF_EN is undefined.
REQ-035 SHALL cover rst asserted after 4 BTUs, then a full frame 8'h3C → only 3C is reported, with outputs at reset values in between.
